// File: rtl/wb_stream_reader_fsm.sv
// Memory-to-stream DMA: Wishbone B3 incrementing-burst reads into a FWFT FIFO, drained as a valid/ready stream.
// Optional bus-error handling and err_o port are compiled in with WB_STREAM_READER_ERR_EN.
module wb_stream_reader_fsm #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               enable,
  input  logic [WB_AW-1:0]   start_adr,
  input  logic [WB_AW-1:0]   buf_size,
  input  logic [WB_AW-1:0]   burst_size,
  output logic               busy,
  output logic [WB_DW-1:0]   tx_cnt,
  output logic [WB_AW-1:0]   wbm_adr_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  output logic [WB_DW-1:0]   stream_data_o,
  output logic               stream_valid_o,
  input  logic               stream_ready_i
`ifdef WB_STREAM_READER_ERR_EN
  , output logic             err_o
`endif
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [WB_AW-1:0] DEPTH_W = WB_AW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST, DRAIN} state_t;

  state_t             state_q, state_d;
  logic               enable_q;
  logic [WB_AW-1:0]   adr_q, adr_d;
  logic [WB_AW-1:0]   remaining_q, remaining_d;
  logic [WB_DW-1:0]   tx_cnt_q, tx_cnt_d;
  logic               busy_q, busy_d;
  logic               cyc_q, cyc_d;
  logic [2:0]         cti_q, cti_d;
  logic [FIFO_AW:0]   beats_q, beats_d;
  logic [FIFO_AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic               valid_q, valid_d;
  logic [WB_DW-1:0]   mem_q [DEPTH];
  logic               push, pop;
  logic [FIFO_AW:0]   fill;
  logic [WB_AW-1:0]   free_w, bs, blen;
`ifdef WB_STREAM_READER_ERR_EN
  logic               err_q, err_d;
  logic               lsb_unused;
  assign lsb_unused = ^start_adr[1:0];
`else
  logic               in_unused;
  assign in_unused = wbm_err_i ^ (^start_adr[1:0]);
`endif

  assign fill   = wptr_q - rptr_q;
  assign free_w = WB_AW'(DEPTH) - WB_AW'(fill);
  assign pop    = valid_q & stream_ready_i;

  // Burst length is clipped to what is left and to the FIFO depth, so a burst always fits once free.
  always_comb begin
    bs   = (burst_size == '0) ? WB_AW'(1) : burst_size;
    blen = (bs < remaining_q) ? bs : remaining_q;
    if (blen > DEPTH_W) blen = DEPTH_W;
  end

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    remaining_d = remaining_q;
    tx_cnt_d    = tx_cnt_q;
    busy_d      = busy_q;
    cyc_d       = cyc_q;
    cti_d       = cti_q;
    beats_d     = beats_q;
    push        = 1'b0;
`ifdef WB_STREAM_READER_ERR_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable && !enable_q) begin
          adr_d       = {start_adr[WB_AW-1:2], 2'b00};
          remaining_d = buf_size;
          tx_cnt_d    = '0;
          busy_d      = 1'b1;
`ifdef WB_STREAM_READER_ERR_EN
          err_d       = 1'b0;
`endif
          state_d     = (buf_size == '0) ? DRAIN : WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (free_w >= blen) begin
          cyc_d   = 1'b1;
          cti_d   = (blen == WB_AW'(1)) ? 3'b111 : 3'b010;
          beats_d = (FIFO_AW+1)'(blen);
          state_d = BURST;
        end
      end
      BURST: begin
`ifdef WB_STREAM_READER_ERR_EN
        if (wbm_err_i) begin
          cyc_d       = 1'b0;
          cti_d       = 3'b000;
          remaining_d = '0;
          err_d       = 1'b1;
          state_d     = DRAIN;
        end else
`endif
        if (wbm_ack_i) begin
          push        = 1'b1;
          adr_d       = adr_q + WB_AW'(4);
          tx_cnt_d    = tx_cnt_q + WB_DW'(1);
          remaining_d = remaining_q - WB_AW'(1);
          beats_d     = beats_q - (FIFO_AW+1)'(1);
          if (beats_q == (FIFO_AW+1)'(1)) begin
            cyc_d   = 1'b0;
            cti_d   = 3'b000;
            state_d = (remaining_q == WB_AW'(1)) ? DRAIN : WAIT_SPACE;
          end else if (beats_q == (FIFO_AW+1)'(2)) begin
            cti_d = 3'b111;
          end
        end
      end
      DRAIN: begin
        if (wptr_q == rptr_q) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q + (FIFO_AW+1)'(push);
    rptr_d  = rptr_q + (FIFO_AW+1)'(pop);
    valid_d = (wptr_d != rptr_d);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      enable_q    <= 1'b0;
      adr_q       <= '0;
      remaining_q <= '0;
      tx_cnt_q    <= '0;
      busy_q      <= 1'b0;
      cyc_q       <= 1'b0;
      cti_q       <= 3'b000;
      beats_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable;
      adr_q       <= adr_d;
      remaining_q <= remaining_d;
      tx_cnt_q    <= tx_cnt_d;
      busy_q      <= busy_d;
      cyc_q       <= cyc_d;
      cti_q       <= cti_d;
      beats_q     <= beats_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      valid_q     <= valid_d;
    end
  end

`ifdef WB_STREAM_READER_ERR_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) err_q <= 1'b0;
    else          err_q <= err_d;
  end
  assign err_o = err_q;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= wbm_dat_i;
  end

  assign busy           = busy_q;
  assign tx_cnt         = tx_cnt_q;
  assign wbm_adr_o      = adr_q;
  assign wbm_sel_o      = '1;
  assign wbm_we_o       = 1'b0;
  assign wbm_cyc_o      = cyc_q;
  assign wbm_stb_o      = cyc_q;
  assign wbm_cti_o      = cti_q;
  assign wbm_bte_o      = 2'b00;
  assign stream_data_o  = mem_q[rptr_q[FIFO_AW-1:0]];
  assign stream_valid_o = valid_q;

endmodule

// File: tb/tb_wb_stream_reader_fsm.sv
// Directed self-checking bench for wb_stream_reader_fsm; exercises the err path when WB_STREAM_READER_ERR_EN is defined.
module tb_wb_stream_reader_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] start_adr, buf_size, burst_size;
  logic        busy;
  logic [31:0] tx_cnt, wbm_adr, wbm_dat;
  logic [3:0]  wbm_sel;
  logic        wbm_we, wbm_cyc, wbm_stb, wbm_ack, wbm_err;
  logic [2:0]  wbm_cti;
  logic [1:0]  wbm_bte;
  logic [31:0] s_data;
  logic        s_valid, s_ready;
  logic        err_inj = 1'b0;
`ifdef WB_STREAM_READER_ERR_EN
  logic        err_o;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] beat_adr[$];
  logic [2:0]  beat_cti[$];
  logic [31:0] str_dat[$];
  int cyc_n = 0, last_hs = 0, last_busy = 0, busy_cycles = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Slave: zero-wait-state acks; optional error on the third beat (tx_cnt==2) of a transfer.
  assign wbm_dat = mdat(wbm_adr);
  assign wbm_err = wbm_cyc & wbm_stb & err_inj & (tx_cnt == 32'd2);
  assign wbm_ack = wbm_cyc & wbm_stb & ~wbm_err;

  wb_stream_reader_fsm #(.WB_AW(32), .WB_DW(32), .FIFO_AW(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .start_adr(start_adr),
    .buf_size(buf_size), .burst_size(burst_size), .busy(busy), .tx_cnt(tx_cnt),
    .wbm_adr_o(wbm_adr), .wbm_dat_i(wbm_dat), .wbm_sel_o(wbm_sel), .wbm_we_o(wbm_we),
    .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_cti_o(wbm_cti), .wbm_bte_o(wbm_bte),
    .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err), .stream_data_o(s_data),
    .stream_valid_o(s_valid), .stream_ready_i(s_ready)
`ifdef WB_STREAM_READER_ERR_EN
    , .err_o(err_o)
`endif
  );

  always @(posedge clk) begin
    cyc_n++;
    if (wbm_cyc && wbm_stb && wbm_ack) begin
      beat_adr.push_back(wbm_adr);
      beat_cti.push_back(wbm_cti);
    end
    if (s_valid && s_ready) begin
      str_dat.push_back(s_data);
      last_hs = cyc_n;
    end
    if (busy) begin
      last_busy = cyc_n;
      busy_cycles++;
    end
  end

  task automatic clear_mon();
    beat_adr.delete();
    beat_cti.delete();
    str_dat.delete();
    busy_cycles = 0;
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic [31:0] s, input logic [31:0] b);
    @(negedge clk);
    start_adr = a; buf_size = s; burst_size = b; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (!busy) begin timed_out = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; s_ready = 1'b1;
    start_adr = '0; buf_size = '0; burst_size = '0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests++; if (tx_cnt !== 32'd0) begin fails++; $display("FAIL reset_tx_cnt got %0d want 0", tx_cnt); end
    tests++; if (wbm_cyc !== 1'b0 || wbm_stb !== 1'b0) begin fails++; $display("FAIL reset_cyc_stb got %0b%0b want 00", wbm_cyc, wbm_stb); end
    tests++; if (wbm_adr !== 32'd0) begin fails++; $display("FAIL reset_adr got %h want 0", wbm_adr); end
    tests++; if (wbm_cti !== 3'b000) begin fails++; $display("FAIL reset_cti got %b want 000", wbm_cti); end
    tests++; if (s_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", s_valid); end
    tests++; if (wbm_sel !== 4'hF || wbm_we !== 1'b0 || wbm_bte !== 2'b00)
      begin fails++; $display("FAIL reset_consts got sel=%h we=%0b bte=%b want F 0 00", wbm_sel, wbm_we, wbm_bte); end
`ifdef WB_STREAM_READER_ERR_EN
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %0b want 0", err_o); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_bursts();
    bit to;
    clear_mon();
    start_xfer(32'h100, 32'd8, 32'd4);
    wait_idle(to);
    tests++; if (to) begin fails++; $display("FAIL two_bursts_done busy stuck got 1 want 0"); end
    tests++; if (beat_adr.size() != 8) begin fails++; $display("FAIL two_bursts_beats got %0d want 8", beat_adr.size()); end
    for (int i = 0; i < beat_adr.size() && i < 8; i++) begin
      tests++;
      if (beat_adr[i] !== 32'h100 + 32'(4*i) || beat_cti[i] !== ((i % 4 == 3) ? 3'b111 : 3'b010)) begin
        fails++; $display("FAIL two_bursts_beat%0d got adr=%h cti=%b want adr=%h cti=%b", i, beat_adr[i], beat_cti[i],
                          32'h100 + 32'(4*i), (i % 4 == 3) ? 3'b111 : 3'b010);
      end
    end
    tests++; if (str_dat.size() != 8) begin fails++; $display("FAIL two_bursts_words got %0d want 8", str_dat.size()); end
    for (int i = 0; i < str_dat.size() && i < 8; i++) begin
      tests++;
      if (str_dat[i] !== mdat(32'h100 + 32'(4*i))) begin
        fails++; $display("FAIL two_bursts_data%0d got %h want %h", i, str_dat[i], mdat(32'h100 + 32'(4*i)));
      end
    end
    tests++; if (tx_cnt !== 32'd8) begin fails++; $display("FAIL two_bursts_tx_cnt got %0d want 8", tx_cnt); end
    tests++; if (!(last_busy > last_hs)) begin fails++; $display("FAIL two_bursts_busy_fall got busy_last=%0d want > hs_last=%0d", last_busy, last_hs); end
  endtask

  task automatic test_short_burst();
    bit to;
    logic [2:0] exp_cti [5] = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b111};
    clear_mon();
    start_xfer(32'h402, 32'd5, 32'd4);
    wait_idle(to);
    tests++; if (to) begin fails++; $display("FAIL short_done busy stuck got 1 want 0"); end
    tests++; if (beat_adr.size() != 5) begin fails++; $display("FAIL short_beats got %0d want 5", beat_adr.size()); end
    for (int i = 0; i < beat_adr.size() && i < 5; i++) begin
      tests++;
      if (beat_adr[i] !== 32'h400 + 32'(4*i) || beat_cti[i] !== exp_cti[i]) begin
        fails++; $display("FAIL short_beat%0d got adr=%h cti=%b want adr=%h cti=%b", i, beat_adr[i], beat_cti[i],
                          32'h400 + 32'(4*i), exp_cti[i]);
      end
    end
    tests++; if (tx_cnt !== 32'd5) begin fails++; $display("FAIL short_tx_cnt got %0d want 5", tx_cnt); end
    tests++; if (str_dat.size() != 5) begin fails++; $display("FAIL short_words got %0d want 5", str_dat.size()); end
  endtask

  task automatic test_backpressure();
    bit to;
    int bad;
    clear_mon();
    s_ready = 1'b0;
    start_xfer(32'h1000, 32'd40, 32'd16);
    repeat (40) @(negedge clk);
    tests++; if (beat_adr.size() != 16) begin fails++; $display("FAIL bp_stall_beats got %0d want 16", beat_adr.size()); end
    tests++; if (wbm_cyc !== 1'b0) begin fails++; $display("FAIL bp_stall_cyc got %0b want 0", wbm_cyc); end
    tests++; if (busy !== 1'b1 || s_valid !== 1'b1) begin fails++; $display("FAIL bp_stall_busy_valid got %0b%0b want 11", busy, s_valid); end
    tests++; if (str_dat.size() != 0) begin fails++; $display("FAIL bp_stall_words got %0d want 0", str_dat.size()); end
    s_ready = 1'b1;
    wait_idle(to);
    tests++; if (to) begin fails++; $display("FAIL bp_done busy stuck got 1 want 0"); end
    tests++; if (beat_adr.size() != 40) begin fails++; $display("FAIL bp_beats got %0d want 40", beat_adr.size()); end
    tests++; if (str_dat.size() != 40) begin fails++; $display("FAIL bp_words got %0d want 40", str_dat.size()); end
    bad = -1;
    for (int i = 0; i < str_dat.size() && i < 40; i++)
      if (bad < 0 && str_dat[i] !== mdat(32'h1000 + 32'(4*i))) bad = i;
    tests++; if (bad >= 0) begin fails++; $display("FAIL bp_order word%0d got %h want %h", bad, str_dat[bad], mdat(32'h1000 + 32'(4*bad))); end
    tests++; if (tx_cnt !== 32'd40) begin fails++; $display("FAIL bp_tx_cnt got %0d want 40", tx_cnt); end
  endtask

  task automatic test_zero_len();
    clear_mon();
    start_xfer(32'h2000, 32'd0, 32'd4);
    repeat (5) @(negedge clk);
    tests++; if (busy_cycles != 1) begin fails++; $display("FAIL zero_busy_cycles got %0d want 1", busy_cycles); end
    tests++; if (beat_adr.size() != 0) begin fails++; $display("FAIL zero_beats got %0d want 0", beat_adr.size()); end
    tests++; if (tx_cnt !== 32'd0) begin fails++; $display("FAIL zero_tx_cnt got %0d want 0", tx_cnt); end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit seen = 1'b0;
    clear_mon();
    start_xfer(32'h200, 32'd8, 32'd4);
    for (int i = 0; i < 20; i++) begin
      if (beat_adr.size() >= 2) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tests++; if (!seen || beat_adr.size() != 2) begin fails++; $display("FAIL midrst_two_acks got %0d want 2", beat_adr.size()); end
    rst = 1'b1;
    #1;
    tests++; if (wbm_cyc !== 1'b0 || wbm_stb !== 1'b0) begin fails++; $display("FAIL midrst_cyc_stb got %0b%0b want 00", wbm_cyc, wbm_stb); end
    tests++; if (s_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %0b want 0", s_valid); end
    tests++; if (busy !== 1'b0 || tx_cnt !== 32'd0) begin fails++; $display("FAIL midrst_busy_cnt got %0b/%0d want 0/0", busy, tx_cnt); end
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    start_xfer(32'h300, 32'd4, 32'd4);
    wait_idle(to);
    tests++; if (to || str_dat.size() != 4) begin fails++; $display("FAIL midrst_rerun_words got %0d want 4", str_dat.size()); end
    for (int i = 0; i < str_dat.size() && i < 4; i++) begin
      tests++;
      if (str_dat[i] !== mdat(32'h300 + 32'(4*i))) begin
        fails++; $display("FAIL midrst_rerun_data%0d got %h want %h", i, str_dat[i], mdat(32'h300 + 32'(4*i)));
      end
    end
    tests++; if (tx_cnt !== 32'd4) begin fails++; $display("FAIL midrst_rerun_tx_cnt got %0d want 4", tx_cnt); end
  endtask

`ifdef WB_STREAM_READER_ERR_EN
  task automatic test_bus_error();
    bit to;
    clear_mon();
    err_inj = 1'b1;
    start_xfer(32'h500, 32'd4, 32'd4);
    wait_idle(to);
    err_inj = 1'b0;
    tests++; if (to) begin fails++; $display("FAIL err_done busy stuck got 1 want 0"); end
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_flag got %0b want 1", err_o); end
    tests++; if (wbm_cyc !== 1'b0) begin fails++; $display("FAIL err_cyc got %0b want 0", wbm_cyc); end
    tests++; if (tx_cnt !== 32'd2) begin fails++; $display("FAIL err_tx_cnt got %0d want 2", tx_cnt); end
    tests++; if (str_dat.size() != 2) begin fails++; $display("FAIL err_words got %0d want 2", str_dat.size()); end
    for (int i = 0; i < str_dat.size() && i < 2; i++) begin
      tests++;
      if (str_dat[i] !== mdat(32'h500 + 32'(4*i))) begin
        fails++; $display("FAIL err_data%0d got %h want %h", i, str_dat[i], mdat(32'h500 + 32'(4*i)));
      end
    end
    clear_mon();
    start_xfer(32'h600, 32'd1, 32'd4);
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_clear got %0b want 0", err_o); end
    wait_idle(to);
    tests++; if (to || tx_cnt !== 32'd1 || beat_cti.size() != 1) begin fails++; $display("FAIL err_next_xfer got tx_cnt=%0d beats=%0d want 1/1", tx_cnt, beat_cti.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_two_bursts();
    test_short_burst();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
`ifdef WB_STREAM_READER_ERR_EN
    test_bus_error();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
